// File: rtl/tick_timer_if.sv
// Control, status and display bundle for tick_timer; the controller drives
// the inputs, the timer drives the outputs.
interface tick_timer_if;
  logic       clk10Hz;
  logic       start;
  logic       pause;
  logic       drain;
  logic       tick;
  logic [3:0] time_hundreds;
  logic [3:0] time_tens;
  logic [3:0] time_ones;
  logic       hurry;
  logic       time_up;
  logic       score_pulse;
  logic       drain_done;
  logic [1:0] state;

  modport master (
    output clk10Hz, start, pause, drain,
    input  tick, time_hundreds, time_tens, time_ones, hurry, time_up, score_pulse,
    input  drain_done, state
  );

  modport slave (
    input  clk10Hz, start, pause, drain,
    output tick, time_hundreds, time_tens, time_ones, hurry, time_up, score_pulse,
    output drain_done, state
  );
endinterface

// File: rtl/tick_timer.sv
// Level countdown timer in BCD: decrements once per TICKS_PER_UNIT slow ticks while running,
// and can drain the remaining time into one score pulse per tick.
module tick_timer #(
  parameter int unsigned START_TIME     = 400,
  parameter int unsigned TICKS_PER_UNIT = 4,
  parameter int unsigned HURRY_TIME     = 100
) (
  input  logic        clk12Mhz,
  input  logic        rst_n,
  tick_timer_if.slave tmr_io
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDrain  = 2'd3
  } state_e;

  localparam logic [3:0] StartHund  = 4'((START_TIME / 100) % 10);
  localparam logic [3:0] StartTens  = 4'((START_TIME / 10) % 10);
  localparam logic [3:0] StartOnes  = 4'(START_TIME % 10);
  localparam logic [7:0] PrescLast  = 8'(TICKS_PER_UNIT - 1);
  localparam logic [9:0] HurryLimit = 10'(HURRY_TIME);

  state_e     state_q, state_d;
  logic [2:0] sync_q;
  logic       tick_q, tick_d;
  logic [3:0] hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [7:0] presc_q, presc_d;
  logic       hurry_q, hurry_d;
  logic       time_up_q, time_up_d;
  logic       score_q, score_d;
  logic       done_q, done_d;

  logic [3:0] dec_hund, dec_tens, dec_ones;
  logic       timer_zero, dec_zero;
  logic [9:0] time_bin_d;

  // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history
  assign tick_d = sync_q[1] & ~sync_q[2];

  // BCD decrement that saturates at 000
  always_comb begin
    dec_hund = hund_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end else if (hund_q != 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = 4'd9;
      dec_hund = hund_q - 4'd1;
    end
  end

  assign timer_zero = ({hund_q, tens_q, ones_q} == 12'd0);
  assign dec_zero   = ({dec_hund, dec_tens, dec_ones} == 12'd0);

  always_comb begin
    state_d   = state_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    presc_d   = presc_q;
    time_up_d = 1'b0;
    score_d   = 1'b0;
    done_d    = 1'b0;
    if (tmr_io.start) begin
      state_d = StRun;
      hund_d  = StartHund;
      tens_d  = StartTens;
      ones_d  = StartOnes;
      presc_d = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tmr_io.drain) state_d = StDrain;
        end
        StRun: begin
          if (tmr_io.drain) begin
            state_d = StDrain;
          end else if (tmr_io.pause) begin
            state_d = StPaused;
          end else if (tick_q) begin
            if (presc_q >= PrescLast) begin
              presc_d = 8'd0;
              hund_d  = dec_hund;
              tens_d  = dec_tens;
              ones_d  = dec_ones;
              if (dec_zero) begin
                state_d   = StIdle;
                time_up_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + 8'd1;
            end
          end
        end
        StPaused: begin
          if (tmr_io.drain) state_d = StDrain;
          else if (!tmr_io.pause) state_d = StRun;
        end
        StDrain: begin
          if (timer_zero) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (tick_q) begin
            hund_d  = dec_hund;
            tens_d  = dec_tens;
            ones_d  = dec_ones;
            score_d = 1'b1;
            if (dec_zero) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      endcase
    end
    time_bin_d = 10'(hund_d) * 10'd100 + 10'(tens_d) * 10'd10 + 10'(ones_d);
    hurry_d    = (state_d != StIdle) && (time_bin_d <= HurryLimit);
  end

  always_ff @(posedge clk12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sync_q    <= 3'd0;
      tick_q    <= 1'b0;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      presc_q   <= 8'd0;
      hurry_q   <= 1'b0;
      time_up_q <= 1'b0;
      score_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], tmr_io.clk10Hz};
      tick_q    <= tick_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      hurry_q   <= hurry_d;
      time_up_q <= time_up_d;
      score_q   <= score_d;
      done_q    <= done_d;
    end
  end

  assign tmr_io.tick          = tick_q;
  assign tmr_io.time_hundreds = hund_q;
  assign tmr_io.time_tens     = tens_q;
  assign tmr_io.time_ones     = ones_q;
  assign tmr_io.hurry         = hurry_q;
  assign tmr_io.time_up       = time_up_q;
  assign tmr_io.score_pulse   = score_q;
  assign tmr_io.drain_done    = done_q;
  assign tmr_io.state         = state_q;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: a default instance and a START_TIME=5 instance share the slow clock;
// every tick queues the expected post-tick snapshot, which per-instance monitors check.
module tb_tick_timer;

  localparam int TPU = 4;

  typedef struct {
    logic [11:0] digits;
    logic [1:0]  state;
    logic        hurry;
    logic        time_up;
    logic        score;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tick_timer_if bus ();
  tick_timer_if bus5 ();
  assign bus5.clk10Hz = bus.clk10Hz;

  tick_timer #(
    .START_TIME     (400),
    .TICKS_PER_UNIT (4),
    .HURRY_TIME     (100)
  ) u_dut (
    .clk12Mhz (clk),
    .rst_n    (rst_n),
    .tmr_io   (bus)
  );

  tick_timer #(
    .START_TIME     (5),
    .TICKS_PER_UNIT (4),
    .HURRY_TIME     (100)
  ) u_dut5 (
    .clk12Mhz (clk),
    .rst_n    (rst_n),
    .tmr_io   (bus5)
  );

  logic [11:0] dig0, dig5;
  assign dig0 = {bus.time_hundreds, bus.time_tens, bus.time_ones};
  assign dig5 = {bus5.time_hundreds, bus5.time_tens, bus5.time_ones};

  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   m_time[2];
  int   m_presc[2];
  int   m_state[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [11:0] d, input logic [1:0] s,
                     input logic h, input logic [2:0] pulses);
    check({tag, "_digits"}, d, e.digits);
    check({tag, "_state"}, s, e.state);
    check({tag, "_hurry"}, h, e.hurry);
    check({tag, "_pulses"}, pulses, {e.time_up, e.score, e.done});
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void model_step(input int id, input logic p);
    exp_t e;
    e.time_up = 1'b0;
    e.score   = 1'b0;
    e.done    = 1'b0;
    if (m_state[id] == 1 && !p) begin
      m_presc[id]++;
      if (m_presc[id] == TPU) begin
        m_presc[id] = 0;
        if (m_time[id] > 0) m_time[id]--;
        if (m_time[id] == 0) begin
          m_state[id] = 0;
          e.time_up   = 1'b1;
        end
      end
    end else if (m_state[id] == 3) begin
      if (m_time[id] > 0) begin
        m_time[id]--;
        e.score = 1'b1;
      end
      if (m_time[id] == 0) begin
        m_state[id] = 0;
        e.done      = 1'b1;
      end
    end
    e.digits = to_bcd(m_time[id]);
    e.state  = 2'(m_state[id]);
    e.hurry  = (m_state[id] != 0) && (m_time[id] <= 100);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // One slow-clock period; the main instance's tick latency and width are checked here
  task automatic do_tick();
    int lat;
    model_step(0, bus.pause);
    model_step(1, bus5.pause);
    bus.clk10Hz = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) lat = i;
    end
    check("tick_latency", lat, 3);
    @(negedge clk);
    check("tick_width", bus.tick, 0);
    repeat (3) @(negedge clk);
    bus.clk10Hz = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin : mon0
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        @(negedge clk);
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon0_queue: got tick expected none (t=%0t)", $time);
        end else begin
          e = q0.pop_front();
          cmp("mon0", e, dig0, bus.state, bus.hurry,
              {bus.time_up, bus.score_pulse, bus.drain_done});
        end
        @(negedge clk);
        check("mon0_pulse_width", {bus.time_up, bus.score_pulse, bus.drain_done}, 0);
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus5.tick === 1'b1) begin
        @(negedge clk);
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon1_queue: got tick expected none (t=%0t)", $time);
        end else begin
          e = q1.pop_front();
          cmp("mon1", e, dig5, bus5.state, bus5.hurry,
              {bus5.time_up, bus5.score_pulse, bus5.drain_done});
        end
        @(negedge clk);
        check("mon1_pulse_width", {bus5.time_up, bus5.score_pulse, bus5.drain_done}, 0);
      end
    end
  end

  initial begin : stim
    bus.clk10Hz = 1'b0;
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.drain   = 1'b0;
    bus5.start  = 1'b0;
    bus5.pause  = 1'b0;
    bus5.drain  = 1'b0;
    rst_n       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_time[i]  = 0;
      m_presc[i] = 0;
      m_state[i] = 0;
    end

    // Reset state, with start held during reset
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus5.start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_digits", dig0, 12'h000);
    check("rst_outs", {bus.tick, bus.hurry, bus.time_up, bus.score_pulse, bus.drain_done}, 0);
    rst_n      = 1'b1;
    bus.start  = 1'b0;
    bus5.start = 1'b0;
    @(negedge clk);
    check("start_in_reset_ignored", bus.state, 0);

    // Countdown from 400
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    m_state[0] = 1;
    m_time[0]  = 400;
    m_presc[0] = 0;
    check("start_state", bus.state, 1);
    check("start_digits", dig0, 12'h400);
    check("start_hurry", bus.hurry, 0);
    repeat (4) do_tick();
    check("t4_digits", dig0, 12'h399);
    repeat (3) do_tick();
    check("t7_digits", dig0, 12'h399);
    do_tick();
    check("t8_digits", dig0, 12'h398);
    repeat (1191) do_tick();
    check("t1199_digits", dig0, 12'h101);
    check("t1199_hurry", bus.hurry, 0);
    do_tick();
    check("t1200_digits", dig0, 12'h100);
    check("t1200_hurry", bus.hurry, 1);
    repeat (399) do_tick();
    check("t1599_digits", dig0, 12'h001);
    check("t1599_state", bus.state, 1);
    do_tick();
    check("expiry_digits", dig0, 12'h000);
    check("expiry_state", bus.state, 0);
    check("expiry_hurry", bus.hurry, 0);
    repeat (20) do_tick();
    check("idle_ticks_digits", dig0, 12'h000);
    check("idle_ticks_state", bus.state, 0);

    // Pause mid-unit: prescaler must hold
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    m_state[0] = 1;
    m_time[0]  = 400;
    m_presc[0] = 0;
    repeat (6) do_tick();
    check("pre_pause_digits", dig0, 12'h399);
    bus.pause = 1'b1;
    @(negedge clk);
    m_state[0] = 2;
    check("pause_state", bus.state, 2);
    repeat (10) do_tick();
    check("pause_frozen", dig0, 12'h399);
    bus.pause = 1'b0;
    @(negedge clk);
    m_state[0] = 1;
    check("resume_state", bus.state, 1);
    do_tick();
    check("resume_t1_digits", dig0, 12'h399);
    do_tick();
    check("resume_t2_digits", dig0, 12'h398);

    // Drain on the START_TIME=5 instance
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    m_state[1] = 1;
    m_time[1]  = 5;
    m_presc[1] = 0;
    check("d5_start_digits", dig5, 12'h005);
    bus5.drain = 1'b1;
    @(negedge clk);
    bus5.drain = 1'b0;
    m_state[1] = 3;
    check("d5_drain_state", bus5.state, 3);
    repeat (5) do_tick();
    check("d5_drained_digits", dig5, 12'h000);
    check("d5_drained_state", bus5.state, 0);
    bus5.drain = 1'b1;
    @(negedge clk);
    bus5.drain = 1'b0;
    check("d5_empty_drain_state", bus5.state, 3);
    check("d5_empty_drain_early", bus5.drain_done, 0);
    @(negedge clk);
    check("d5_empty_drain_done", {bus5.drain_done, bus5.score_pulse}, 2'b10);
    check("d5_empty_drain_idle", bus5.state, 0);
    @(negedge clk);
    check("d5_empty_drain_width", bus5.drain_done, 0);

    // Asynchronous reset between clock edges while running
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", bus.state, 0);
    check("async_rst_digits", dig0, 12'h000);
    check("async_rst_outs", {bus.tick, bus.hurry, bus.time_up, bus.score_pulse, bus.drain_done},
          0);
    for (int i = 0; i < 2; i++) begin
      m_time[i]  = 0;
      m_presc[i] = 0;
      m_state[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start and pause together: RUN first, PAUSED next
    bus.start = 1'b1;
    bus.pause = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_pause_run", bus.state, 1);
    check("start_pause_digits", dig0, 12'h400);
    @(negedge clk);
    check("start_pause_paused", bus.state, 2);
    bus.pause = 1'b0;
    @(negedge clk);
    check("start_pause_resume", bus.state, 1);

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter START_TIME, default 400, level timer load value in decimal (0-999).
REQ-002 Parameter TICKS_PER_UNIT, default 4, number of ticks per one-unit timer decrement (1-255).
REQ-003 Parameter HURRY_TIME, default 100, threshold at or below which hurry is raised.
REQ-004 clk12Mhz  in  1  sole system clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clk10Hz  in  1  slow divided clock from the divider, treated as an asynchronous level.
REQ-007 start  in  1  one-cycle request to load START_TIME and run.
REQ-008 pause  in  1  level; freezes the countdown while high.
REQ-009 drain  in  1  one-cycle request to convert the remaining time to score.
REQ-010 tick  out  1  one-cycle pulse per rising edge of clk10Hz.
REQ-011 time_hundreds, time_tens, time_ones  out  4 each  BCD timer digits.
REQ-012 hurry  out  1  level; timer at or below HURRY_TIME while not IDLE.
REQ-013 time_up  out  1  one-cycle pulse when RUN expires.
REQ-014 score_pulse  out  1  one-cycle pulse per drained time unit.
REQ-015 drain_done  out  1  one-cycle pulse when the drain completes.
REQ-016 state  out  2  encoding: IDLE=0, RUN=1, PAUSED=2, DRAIN=3.

Function
REQ-017 clk10Hz SHALL pass through a 2-flop synchronizer, followed by a third flop for edge detection.
REQ-018 tick SHALL be registered and high for exactly one cycle, on the 3rd clk12Mhz edge after the first edge that samples clk10Hz high.
REQ-019 tick SHALL be generated in all states.
REQ-020 start SHALL have top priority in any state: load START_TIME, clear the prescaler, and enter RUN on the next edge.
REQ-021 Priority when inputs coincide SHALL be start > drain > pause.
REQ-022 IDLE: pause SHALL be ignored; drain SHALL enter DRAIN.
REQ-023 RUN: pause high SHALL move to PAUSED; drain SHALL move to DRAIN.
REQ-024 PAUSED: pause low SHALL return to RUN; drain SHALL move to DRAIN.
REQ-025 Prescaler SHALL count modulo TICKS_PER_UNIT, advancing on tick only when state is RUN and pause is low.
REQ-026 The prescaler SHALL hold its value in PAUSED.
REQ-027 On prescaler wrap, the timer SHALL decrement by 1 in BCD, with borrows across digits (e.g. 400 -> 399, 100 -> 099).
REQ-028 When a decrement reaches 000, the same edge SHALL move state to IDLE and assert time_up; the digits SHALL hold at 000.
REQ-029 DRAIN SHALL decrement the timer by 1 on each tick and assert score_pulse on the same edge as each decrement.
REQ-030 When a DRAIN decrement reaches 000, that edge SHALL assert drain_done and move to IDLE.
REQ-031 Entering DRAIN with timer 000 SHALL assert drain_done on the next edge with zero score_pulses.
REQ-032 The timer SHALL never wrap below 000.
REQ-033 Ticks in IDLE SHALL leave the digits unchanged.
REQ-034 hurry SHALL be registered and updated on the same edge as the digits.
REQ-035 All pulse outputs SHALL be registered and one cycle wide.

Reset
REQ-036 rst_n low SHALL immediately, without a clock edge, force: state IDLE, digits 000, prescaler 0, synchronizer flops 0, and all outputs 0.
REQ-037 A release of rst_n SHALL take effect at the first rising edge of clk12Mhz at which rst_n is sampled high.
REQ-038 A start coincident with reset SHALL be ignored.

Verification
REQ-039 Reset, start (400/4/100): after 4 ticks, digits 3,9,9; after 3 more ticks, still 399; after 8 ticks total, 398.
REQ-040 Run 1200 ticks from 400: hurry rises on the edge the digits become 1,0,0; tick latency is 3 cycles from the clk10Hz edge.
REQ-041 Run to expiry: 1600 ticks -> digits 000, time_up for 1 cycle, state 0; 20 further ticks leave everything unchanged.
REQ-042 Pause after 2 ticks of a unit, hold pause for 10 ticks (digits frozen), release -> the 2nd tick after release decrements.
REQ-043 START_TIME=5, then drain -> 5 score_pulses on 5 consecutive ticks, drain_done with the last, state 0; a second drain gives an immediate drain_done.
REQ-044 Assert rst_n low mid-RUN between clock edges -> outputs clear immediately; start and pause asserted together -> RUN wins, then PAUSED on the following edge.
